mnd_unit: RTL and testbench

- Execute-stage multiply/divide unit; consumes the MND control bundle (type, start, HI/LO write enable) and operands issued by the D->E pipeline register.
- Owns architectural HI/LO registers, models fixed multi-cycle latency, and exposes a busy flag to the hazard unit for stalling.
- Honours the interrupt/exception request so that a flushed instruction never modifies HI/LO.

---
 rtl/mnd_unit.sv | 153 +++++++++++++++
 tb/tb_mnd_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mnd_unit.sv
// mnd_unit -- execute-stage multiply/divide unit.
//
// Owns the architectural HI/LO registers. An accepted operation computes its
// full 64-bit result up front, holds it as a pending value, and commits it to
// {hi,lo} after a fixed latency. The latency is MULT_CYCLES or DIV_CYCLES,
// during which busy is high.
//
// Ports:
//   clk        in   1   clock, rising edge
//   reset      in   1   synchronous, active-high reset
//   mnd_type   in   4   0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 madd,
//                       6 maddu, 7 msub, 8 msubu, 9..15 none
//   mnd_start  in   1   launch mnd_type this cycle
//   mnd_we     in   2   01 mthi, 10 mtlo, 00/11 none
//   cancel     in   1   interrupt/exception flush of the current instruction
//   src_a      in  32   rs operand (also the mthi/mtlo data)
//   src_b      in  32   rt operand
//   busy       out  1   operation in flight
//   hi, lo     out 32   architectural HI/LO
//
// Start/busy handshake: an op is taken at a rising edge when mnd_start is high,
// mnd_type is 1..8, cancel is low and busy is low. busy is purely registered,
// and starts offered while busy are dropped rather than queued. The hazard
// unit is expected to OR mnd_start with busy to build its stall.
module mnd_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  mnd_type,
   input  logic        mnd_start,
   input  logic [1:0]  mnd_we,
   input  logic        cancel,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MADD  = 4'd5;
   localparam logic [3:0] OP_MADDU = 4'd6;
   localparam logic [3:0] OP_MSUB  = 4'd7;
   localparam logic [3:0] OP_MSUBU = 4'd8;

   logic [31:0] hi_q, lo_q;
   logic        busy_q;
   logic [3:0]  cnt_q;
   logic [63:0] pend_q;
   logic        commit_en_q;   // low when the pending op must not touch HI/LO

   logic [63:0] result_d;
   logic [3:0]  len_d;
   logic        commit_en_d;
   logic        accept;

   logic [63:0] a_sx, b_sx, prod_s, prod_u, acc;
   logic [31:0] a_mag, b_mag, sq_mag, sr_mag, sq, sr, uq, ur;
   logic        div_zero;

   assign accept = mnd_start && !busy_q && !cancel &&
                   (mnd_type >= OP_MULT) && (mnd_type <= OP_MSUBU);

   always_comb begin
      // The low 64 bits of the product of sign-extended operands equal the
      // signed 32x32 product, so one 64-bit multiplier form covers both.
      a_sx     = {{32{src_a[31]}}, src_a};
      b_sx     = {{32{src_b[31]}}, src_b};
      prod_s   = a_sx * b_sx;
      prod_u   = {32'd0, src_a} * {32'd0, src_b};
      acc      = {hi_q, lo_q};

      // Signed division on magnitudes. The quotient sign is the XOR of the
      // operand signs and the remainder takes the dividend sign.
      // 0x80000000 / -1 yields a magnitude of 0x80000000 with a positive
      // sign, which wraps to 0x80000000 with a remainder of 0.
      div_zero = (src_b == 32'd0);
      a_mag    = src_a[31] ? (32'd0 - src_a) : src_a;
      b_mag    = src_b[31] ? (32'd0 - src_b) : src_b;
      sq_mag   = div_zero ? 32'd0 : (a_mag / b_mag);
      sr_mag   = div_zero ? 32'd0 : (a_mag % b_mag);
      sq       = (src_a[31] ^ src_b[31]) ? (32'd0 - sq_mag) : sq_mag;
      sr       = src_a[31] ? (32'd0 - sr_mag) : sr_mag;
      uq       = div_zero ? 32'd0 : (src_a / src_b);
      ur       = div_zero ? 32'd0 : (src_a % src_b);

      result_d    = 64'd0;
      len_d       = 4'(MULT_CYCLES);
      commit_en_d = 1'b1;
      case (mnd_type)
         OP_MULT:  result_d = prod_s;
         OP_MULTU: result_d = prod_u;
         OP_MADD:  result_d = acc + prod_s;
         OP_MADDU: result_d = acc + prod_u;
         OP_MSUB:  result_d = acc - prod_s;
         OP_MSUBU: result_d = acc - prod_u;
         OP_DIV: begin
            result_d    = {sr, sq};
            len_d       = 4'(DIV_CYCLES);
            commit_en_d = !div_zero;
         end
         OP_DIVU: begin
            result_d    = {ur, uq};
            len_d       = 4'(DIV_CYCLES);
            commit_en_d = !div_zero;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hi_q        <= 32'd0;
         lo_q        <= 32'd0;
         busy_q      <= 1'b0;
         cnt_q       <= 4'd0;
         pend_q      <= 64'd0;
         commit_en_q <= 1'b0;
      end else if (accept) begin
         // An accepted start wins over a same-cycle mthi/mtlo.
         pend_q      <= result_d;
         cnt_q       <= len_d;
         commit_en_q <= commit_en_d;
         busy_q      <= 1'b1;
      end else if (busy_q) begin
         // cancel is ignored here, so an in-flight op always completes.
         cnt_q <= cnt_q - 4'd1;
         if (cnt_q == 4'd1) begin
            busy_q <= 1'b0;
            if (commit_en_q) begin
               hi_q <= pend_q[63:32];
               lo_q <= pend_q[31:0];
            end
         end
      end else if (!cancel) begin
         case (mnd_we)
            2'b01:   hi_q <= src_a;
            2'b10:   lo_q <= src_a;
            default: ;
         endcase
      end
   end

   assign busy = busy_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_mnd_unit.sv
// Testbench for mnd_unit: directed operations with hand-computed results.
// Each issued operation pushes {busy_len, hi, lo} into exp_q. A monitor on the
// falling clock edge measures every busy window and checks that hi/lo hold
// steady inside it. When busy drops, the monitor pops exp_q and compares.
module tb_mnd_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  mnd_type;
   logic        mnd_start;
   logic [1:0]  mnd_we;
   logic        cancel;
   logic [31:0] src_a, src_b;
   logic        busy;
   logic [31:0] hi, lo;

   int checks = 0;
   int errors = 0;
   logic [71:0] exp_q[$];   // {len[7:0], hi, lo}

   // ---------------- clock / DUT ----------------
   always #5 clk = ~clk;

   mnd_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .mnd_type(mnd_type), .mnd_start(mnd_start),
      .mnd_we(mnd_we), .cancel(cancel), .src_a(src_a), .src_b(src_b),
      .busy(busy), .hi(hi), .lo(lo)
   );

   // ---------------- checking helpers ----------------
   task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push_exp(input int len, input logic [31:0] eh, input logic [31:0] el);
      exp_q.push_back({8'(len), eh, el});
   endtask

   task automatic check_state(input string name, input logic eb, input logic [31:0] eh, input logic [31:0] el);
      @(negedge clk);
      check64({name, "_busy"}, {63'd0, busy}, {63'd0, eb});
      check64({name, "_hilo"}, {hi, lo}, {eh, el});
   endtask

   // ---------------- monitor / scoreboard ----------------
   logic        prev_busy = 1'b0;
   int          blen = 0;
   logic [63:0] held = 64'd0;
   logic        hold_ok = 1'b1;
   logic [71:0] e;

   always @(negedge clk) begin
      if (busy === 1'b1 && !prev_busy) begin
         blen    = 1;
         held    = {hi, lo};
         hold_ok = 1'b1;
      end else if (busy === 1'b1) begin
         blen++;
         if ({hi, lo} !== held) hold_ok = 1'b0;
      end else if (prev_busy) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_busy_end: got len %0d hilo %h expected nothing", blen, {hi, lo});
         end else begin
            e = exp_q.pop_front();
            check64("busy_len", 64'(blen), {56'd0, e[71:64]});
            check64("commit_hilo", {hi, lo}, e[63:0]);
            check64("hold_while_busy", {63'd0, hold_ok}, 64'd1);
         end
      end
      prev_busy = (busy === 1'b1);
   end

   // ---------------- driver tasks ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Presents a start for one cycle. It returns just after the sampling edge,
   // so an accepted op is in its first busy cycle.
   task automatic start_op(input logic [3:0] t, input logic [31:0] a, input logic [31:0] b, input logic c);
      cyc();
      mnd_type  = t;
      mnd_start = 1'b1;
      src_a     = a;
      src_b     = b;
      cancel    = c;
      cyc();
      mnd_start = 1'b0;
      mnd_type  = 4'd0;
      cancel    = 1'b0;
   endtask

   task automatic write_hl(input logic [1:0] we, input logic [31:0] a, input logic c);
      cyc();
      mnd_we = we;
      src_a  = a;
      cancel = c;
      cyc();
      mnd_we = 2'b00;
      cancel = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (busy === 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check64({name, "_idle_timeout"}, {63'd0, busy}, 64'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset = 1'b1; mnd_type = 4'd0; mnd_start = 1'b0; mnd_we = 2'b00;
      cancel = 1'b0; src_a = 32'd0; src_b = 32'd0;
      repeat (3) cyc();
      reset = 1'b0;
      check_state("reset", 1'b0, 32'h0, 32'h0);

      // mult -2 * 3
      push_exp(5, 32'hFFFFFFFF, 32'hFFFFFFFA);
      start_op(4'd1, 32'hFFFFFFFE, 32'd3, 1'b0);
      wait_idle("mult");

      // multu, with a div offered mid-flight that must be ignored
      push_exp(5, 32'h00000001, 32'hFFFFFFFE);
      start_op(4'd2, 32'hFFFFFFFF, 32'd2, 1'b0);
      start_op(4'd3, 32'd7, 32'd2, 1'b0);
      wait_idle("multu");
      repeat (2) cyc();
      check_state("after_multu", 1'b0, 32'h00000001, 32'hFFFFFFFE);

      // div -7 / 2, divu by zero, 7 / -2, and the overflow corner
      push_exp(10, 32'hFFFFFFFF, 32'hFFFFFFFD);
      start_op(4'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
      wait_idle("div");
      push_exp(10, 32'hFFFFFFFF, 32'hFFFFFFFD);
      start_op(4'd4, 32'd7, 32'd0, 1'b0);
      wait_idle("divu_zero");
      push_exp(10, 32'h00000001, 32'hFFFFFFFD);
      start_op(4'd3, 32'd7, 32'hFFFFFFFE, 1'b0);
      wait_idle("div_negdivisor");
      push_exp(10, 32'h00000000, 32'h80000000);
      start_op(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
      wait_idle("div_ovf");

      // mthi/mtlo then accumulate ops
      write_hl(2'b01, 32'h12345678, 1'b0);
      write_hl(2'b10, 32'h00000001, 1'b0);
      check_state("mthi_mtlo", 1'b0, 32'h12345678, 32'h00000001);
      push_exp(5, 32'h12345678, 32'h00000007);
      start_op(4'd5, 32'd2, 32'd3, 1'b0);
      wait_idle("madd");
      push_exp(5, 32'h12345677, 32'hFFFFFFFF);
      start_op(4'd7, 32'd1, 32'd8, 1'b0);
      wait_idle("msub");
      push_exp(5, 32'h12345676, 32'h00000000);
      start_op(4'd6, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
      wait_idle("maddu");
      push_exp(5, 32'h12345675, 32'hFFFFFFFF);
      start_op(4'd8, 32'd1, 32'd1, 1'b0);
      wait_idle("msubu");
      push_exp(5, 32'h12345676, 32'h00000000);
      start_op(4'd7, 32'hFFFFFFFF, 32'd1, 1'b0);
      wait_idle("msub_neg");

      // cancelled start, out-of-range op, cancelled mtlo
      start_op(4'd1, 32'd5, 32'd5, 1'b1);
      check_state("cancel_start", 1'b0, 32'h12345676, 32'h00000000);
      start_op(4'd9, 32'd5, 32'd5, 1'b0);
      check_state("type9_start", 1'b0, 32'h12345676, 32'h00000000);
      write_hl(2'b10, 32'h00000055, 1'b1);
      check_state("cancel_mtlo", 1'b0, 32'h12345676, 32'h00000000);

      // div 100/7 with an mtlo attempt and then cancel raised while busy
      push_exp(10, 32'h00000002, 32'h0000000E);
      start_op(4'd3, 32'd100, 32'd7, 1'b0);
      mnd_we = 2'b10; src_a = 32'h0000DEAD;
      cyc();
      mnd_we = 2'b00; cancel = 1'b1;
      repeat (3) cyc();
      cancel = 1'b0;
      wait_idle("div_cancel_inflight");

      // reset on the third busy cycle of a mult
      push_exp(3, 32'h0, 32'h0);
      start_op(4'd1, 32'd3, 32'd4, 1'b0);
      cyc();
      cyc();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      check_state("reset_midop", 1'b0, 32'h0, 32'h0);
      repeat (10) cyc();
      check_state("no_late_commit", 1'b0, 32'h0, 32'h0);

      repeat (3) cyc();
      check64("exp_q_drained", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global time bound so the run always ends.
   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
